// File: rtl/mac_feeder_pkg.sv
// Shared types and constants for the 5x5 MAC window feeder.
package mac_feeder_pkg;

  typedef enum logic [1:0] {
    LOAD_FILT = 2'd0,
    FILL      = 2'd1,
    EMIT      = 2'd2,
    NEXT_ROW  = 2'd3
  } state_t;

  localparam int K_SIZE   = 5;
  localparam int WIN_BITS = 25;

endpackage

// File: rtl/row_line_buf.sv
// Five-row shift buffer of ifmap rows; row0 is the oldest, row4 the newest.
module row_line_buf
  import mac_feeder_pkg::*;
#(
  parameter int ROW_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift,
  input  logic [ROW_LEN-1:0] new_row,
  output logic [ROW_LEN-1:0] row0,
  output logic [ROW_LEN-1:0] row1,
  output logic [ROW_LEN-1:0] row2,
  output logic [ROW_LEN-1:0] row3,
  output logic [ROW_LEN-1:0] row4
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row0 <= '0;
      row1 <= '0;
      row2 <= '0;
      row3 <= '0;
      row4 <= '0;
    end else if (shift) begin
      row0 <= row1;
      row1 <= row2;
      row2 <= row3;
      row3 <= row4;
      row4 <= new_row;
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// Streams 5x5 ifmap windows plus a stored 5x5 filter to a MAC array.
// Build macro MAC_FEEDER_FILTER_REUSE_EN keeps the filter across images.
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int FILTER_WIDTH = 8,
  parameter int ROW_LEN      = 8,
  parameter int NUM_ROWS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      filt_valid,
  output logic                      filt_ready,
  input  logic [FILTER_WIDTH*5-1:0] filt_data,
  input  logic                      row_valid,
  output logic                      row_ready,
  input  logic [ROW_LEN-1:0]        row_data,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [WIN_BITS-1:0]       win_data,
  output logic                      win_last,
  output logic [FILTER_WIDTH*5-1:0] f_row1,
  output logic [FILTER_WIDTH*5-1:0] f_row2,
  output logic [FILTER_WIDTH*5-1:0] f_row3,
  output logic [FILTER_WIDTH*5-1:0] f_row4,
  output logic [FILTER_WIDTH*5-1:0] f_row5,
  output logic                      busy
);

  localparam int RW = $clog2(NUM_ROWS + 1);
  localparam int KW = $clog2(ROW_LEN);
  localparam logic [KW-1:0] LAST_K    = KW'(ROW_LEN - K_SIZE);
  localparam logic [RW-1:0] ROWS_ALL  = RW'(NUM_ROWS);
  localparam logic [RW-1:0] ROWS_FILL = RW'(K_SIZE - 1);
`ifdef MAC_FEEDER_FILTER_REUSE_EN
  localparam state_t DONE_STATE = FILL;
`else
  localparam state_t DONE_STATE = LOAD_FILT;
`endif

  state_t state, state_next;
  logic [2:0]         filt_cnt;
  logic [RW-1:0]      row_cnt;
  logic [KW-1:0]      k, k_load;
  logic               ready_en;
  logic               filt_fire, row_fire, win_fire, last_k, last_next;
  logic [ROW_LEN-1:0] rows    [K_SIZE];
  logic [ROW_LEN-1:0] shifted [K_SIZE];
  logic [WIN_BITS-1:0] win_next;

  row_line_buf #(.ROW_LEN(ROW_LEN)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .shift   (row_fire),
    .new_row (row_data),
    .row0    (rows[0]),
    .row1    (rows[1]),
    .row2    (rows[2]),
    .row3    (rows[3]),
    .row4    (rows[4])
  );

  // ready_en holds filt_ready low until the first clock after reset release
  assign filt_ready = (state == LOAD_FILT) && ready_en;
  assign row_ready  = (state == FILL) || (state == NEXT_ROW);
  assign busy       = (state != LOAD_FILT);
  assign filt_fire  = filt_valid && filt_ready;
  assign row_fire   = row_valid && row_ready;
  assign win_fire   = win_valid && win_ready;
  assign last_k     = (k == LAST_K);
  // First window of a row loads at k; later windows load at k+1 on a transfer
  assign k_load     = win_valid ? k + 1'b1 : k;
  assign last_next  = (k_load == LAST_K) && (row_cnt == ROWS_ALL);

  for (genvar i = 0; i < K_SIZE; i++) begin : g_shift
    assign shifted[i] = rows[i] >> k_load;
  end
  for (genvar r = 0; r < K_SIZE; r++) begin : g_row
    for (genvar c = 0; c < K_SIZE; c++) begin : g_col
      assign win_next[K_SIZE*r+c] = shifted[K_SIZE-1-r][c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD_FILT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_FILT: if (filt_fire && filt_cnt == 3'd4) state_next = FILL;
      FILL:      if (row_fire && row_cnt == ROWS_FILL) state_next = EMIT;
      EMIT:      if (win_fire && last_k)
                   state_next = (row_cnt == ROWS_ALL) ? DONE_STATE : NEXT_ROW;
      NEXT_ROW:  if (row_fire) state_next = EMIT;
      default:   state_next = LOAD_FILT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en  <= 1'b0;
      filt_cnt  <= '0;
      row_cnt   <= '0;
      k         <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_data  <= '0;
      f_row1    <= '0;
      f_row2    <= '0;
      f_row3    <= '0;
      f_row4    <= '0;
      f_row5    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (filt_fire) begin
        case (filt_cnt)
          3'd0:    f_row1 <= filt_data;
          3'd1:    f_row2 <= filt_data;
          3'd2:    f_row3 <= filt_data;
          3'd3:    f_row4 <= filt_data;
          default: f_row5 <= filt_data;
        endcase
        filt_cnt <= (filt_cnt == 3'd4) ? 3'd0 : filt_cnt + 3'd1;
      end
      if (row_fire) row_cnt <= row_cnt + 1'b1;
      if (state == EMIT) begin
        if (!win_valid) begin
          win_valid <= 1'b1;
          win_data  <= win_next;
          win_last  <= last_next;
        end else if (win_ready) begin
          if (last_k) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            k         <= '0;
            if (row_cnt == ROWS_ALL) row_cnt <= '0;
          end else begin
            k        <= k + 1'b1;
            win_data <= win_next;
            win_last <= last_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed self-checking bench for mac_feeder (default 8x8 image, 8-bit filter).
module tb_mac_feeder;

  localparam int FW = 8;
  localparam int RL = 8;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          filt_valid = 1'b0;
  logic          filt_ready;
  logic [FW*5-1:0] filt_data = '0;
  logic          row_valid = 1'b0;
  logic          row_ready;
  logic [RL-1:0] row_data = '0;
  logic          win_valid;
  logic          win_ready = 1'b0;
  logic [24:0]   win_data;
  logic          win_last;
  logic [FW*5-1:0] f_row1, f_row2, f_row3, f_row4, f_row5;
  logic          busy;

  mac_feeder #(.FILTER_WIDTH(FW), .ROW_LEN(RL), .NUM_ROWS(NR)) dut (
    .clk(clk), .reset(reset),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .win_last(win_last),
    .f_row1(f_row1), .f_row2(f_row2), .f_row3(f_row3), .f_row4(f_row4), .f_row5(f_row5),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0]  img [8];
  logic [24:0] got [16];
  int n_win = 0;
  int bp_at = -1;

  // rows: row0 (oldest) in the low byte; wins: window k=0 in the low 25 bits
  typedef struct packed {
    logic [4:0][7:0]  rows;
    logic [3:0][24:0] wins;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] exp_win(input int oldest, input int k);
    logic [24:0] e;
    logic [7:0]  rv;
    e = '0;
    for (int r = 0; r < 5; r++) begin
      rv = img[oldest + 4 - r] >> k;
      for (int c = 0; c < 5; c++) e[5*r+c] = rv[c];
    end
    return e;
  endfunction

  task automatic send_filt(input logic [39:0] w);
    int t = 0;
    @(negedge clk);
    filt_valid = 1'b1;
    filt_data  = w;
    while (!filt_ready && t < 50) begin @(negedge clk); t++; end
    chk("filt_ready_wait", filt_ready, 1);
    if (filt_ready) @(posedge clk);
    #1 filt_valid = 1'b0;
  endtask

  task automatic send_row(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    row_valid = 1'b1;
    row_data  = d;
    while (!row_ready && t < 50) begin @(negedge clk); t++; end
    chk("row_ready_wait", row_ready, 1);
    if (row_ready) @(posedge clk);
    #1 row_valid = 1'b0;
  endtask

  task automatic get_win(input logic [24:0] ed, input logic el);
    int t = 0;
    @(negedge clk);
    while (!win_valid && t < 50) begin @(negedge clk); t++; end
    chk("win_valid_wait", win_valid, 1);
    if (n_win == bp_at) begin
      repeat (10) begin
        chk("bp_valid", win_valid, 1);
        chk("bp_data", win_data, ed);
        @(negedge clk);
      end
    end
    chk($sformatf("win_data[%0d]", n_win), win_data, ed);
    chk($sformatf("win_last[%0d]", n_win), win_last, el);
    if (n_win < 16) got[n_win] = win_data;
    win_ready = 1'b1;
    @(posedge clk);
    #1 win_ready = 1'b0;
    n_win++;
  endtask

  task automatic load_filter(input int base);
    for (int i = 0; i < 5; i++) send_filt({5{8'(base + i)}});
  endtask

  task automatic run_image();
    n_win = 0;
    for (int i = 0; i < 5; i++) send_row(img[i]);
    for (int o = 0; o < NR - 4; o++) begin
      for (int k = 0; k < RL - 4; k++) get_win(exp_win(o, k), (o == NR - 5) && (k == RL - 5));
      if (o < NR - 5) send_row(img[o + 5]);
    end
    repeat (3) @(negedge clk);
    chk("no_extra_window", win_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{rows: 40'h00_00_00_00_01, wins: {25'h0, 25'h0, 25'h0, 25'h0100000}};
    vt[1] = '{rows: 40'h01_00_00_00_00, wins: {25'h0, 25'h0, 25'h0, 25'h0000001}};
    vt[2] = '{rows: 40'h00_00_00_00_10, wins: {25'h0200000, 25'h0400000, 25'h0800000, 25'h1000000}};
    vt[3] = '{rows: 40'h00_00_80_00_00, wins: {25'h0004000, 25'h0, 25'h0, 25'h0}};
    vt[4] = '{rows: 40'h0F_00_00_00_F0, wins: {25'h1E00001, 25'h1C00003, 25'h1800007, 25'h100000F}};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_filt_ready", filt_ready, 0);
    chk("rst_row_ready", row_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_f_row1", f_row1, 0);
    reset = 1'b0;
    #1 chk("filt_ready_before_clk", filt_ready, 0);
    @(negedge clk);
    chk("filt_ready_after_clk", filt_ready, 1);

    // filter load
    load_filter(1);
    @(negedge clk);
    chk("f_row1", f_row1, 40'h0101010101);
    chk("f_row3", f_row3, 40'h0303030303);
    chk("f_row5", f_row5, 40'h0505050505);
    chk("load_busy", busy, 1);
    chk("load_filt_ready", filt_ready, 0);
    chk("load_row_ready", row_ready, 1);

    // full image of ones
    for (int i = 0; i < 8; i++) img[i] = 8'hFF;
    run_image();
    chk("ones_first", got[0], 25'h1FFFFFF);
    chk("ones_last", got[15], 25'h1FFFFFF);

    // second image back to back
    for (int i = 0; i < 8; i++) img[i] = 8'(8'h35 * (i + 1));
`ifdef MAC_FEEDER_FILTER_REUSE_EN
    chk("reuse_filt_ready", filt_ready, 0);
    chk("reuse_row_ready", row_ready, 1);
    chk("reuse_busy", busy, 1);
    run_image();
    chk("reuse_f_row1_kept", f_row1, 40'h0101010101);
`else
    chk("new_filt_ready", filt_ready, 1);
    chk("new_row_ready", row_ready, 0);
    chk("new_busy", busy, 0);
    load_filter(6);
    @(negedge clk);
    chk("new_f_row1", f_row1, 40'h0606060606);
    chk("new_f_row5", f_row5, 40'h0A0A0A0A0A);
    run_image();
    chk("done_filt_ready", filt_ready, 1);
`endif

    // table-driven window mapping
    for (int v = 0; v < 5; v++) begin
      do_reset();
      load_filter(1);
      for (int i = 0; i < 8; i++) img[i] = (i < 5) ? vt[v].rows[i] : 8'h00;
      run_image();
      for (int k = 0; k < 4; k++) chk($sformatf("vec%0d_win%0d", v, k), got[k], vt[v].wins[k]);
    end

    // backpressure in the middle of the second row of windows
    do_reset();
    load_filter(1);
    for (int i = 0; i < 8; i++) img[i] = 8'(1 << i);
    bp_at = 5;
    run_image();
    bp_at = -1;

    // reset while window 6 is presented
    do_reset();
    load_filter(1);
    for (int i = 0; i < 8; i++) img[i] = 8'(8'h5A ^ (i * 8'h11));
    n_win = 0;
    for (int i = 0; i < 5; i++) send_row(img[i]);
    for (int k = 0; k < 4; k++) get_win(exp_win(0, k), 1'b0);
    send_row(img[5]);
    get_win(exp_win(1, 0), 1'b0);
    begin
      int t = 0;
      @(negedge clk);
      while (!win_valid && t < 50) begin @(negedge clk); t++; end
      chk("w6_valid", win_valid, 1);
    end
    reset = 1'b1;
    #1;
    chk("mid_win_valid", win_valid, 0);
    chk("mid_win_last", win_last, 0);
    chk("mid_win_data", win_data, 0);
    chk("mid_row_ready", row_ready, 0);
    chk("mid_filt_ready", filt_ready, 0);
    chk("mid_busy", busy, 0);
    chk("mid_f_row1", f_row1, 0);
    chk("mid_f_row5", f_row5, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_filt_ready_after", filt_ready, 1);
    load_filter(1);
    for (int i = 0; i < 8; i++) img[i] = 8'(8'hC3 + i);
    run_image();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
